// File: rtl/func_sweep_ctrl.sv
// Exhaustive 4-input functional sweep controller: drives all 16 vectors to an
// SOP and a POS implementation and compares both against a latched truth table.
module func_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic        s_sop,
  input  logic        s_pos,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      state_r, state_s;
  logic [3:0]  abcd_r, abcd_s;
  logic [3:0]  wait_r, wait_s;
  logic [15:0] gold_r, gold_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [3:0]  first_r, first_s;
  logic        valid_r, valid_s;
  logic        pass_r, pass_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        fail_s;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_s = state_r;
    abcd_s  = abcd_r;
    wait_s  = wait_r;
    gold_s  = gold_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    valid_s = valid_r;
    pass_s  = pass_r;
    done_s  = 1'b0;
    fail_s  = (s_sop != gold_r[abcd_r]) || (s_pos != gold_r[abcd_r]);

    case (state_r)
      ST_IDLE: begin
        // abort dominates a simultaneous start
        if (start && !abort) begin
          gold_s  = golden;
          cnt_s   = 5'd0;
          first_s = 4'd0;
          valid_s = 1'b0;
          pass_s  = 1'b0;
          abcd_s  = 4'd0;
          wait_s  = 4'd0;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_s = ST_IDLE;
          pass_s  = 1'b0;
          abcd_s  = 4'd0;
          wait_s  = 4'd0;
        end else if (wait_r == SETTLE_M1) begin
          wait_s  = 4'd0;
          state_s = ST_CHECK;
        end else begin
          wait_s  = wait_r + 4'd1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_s = ST_IDLE;
          pass_s  = 1'b0;
          abcd_s  = 4'd0;
          wait_s  = 4'd0;
        end else begin
          if (fail_s) begin
            cnt_s = cnt_r + 5'd1;
            if (!valid_r) begin
              first_s = abcd_r;
              valid_s = 1'b1;
            end else begin
              first_s = first_r;
            end
          end else begin
            cnt_s = cnt_r;
          end
          // last vector: stop at 15 and publish the verdict with the final count
          if (abcd_r == 4'd15) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            pass_s  = (cnt_s == 5'd0);
          end else begin
            abcd_s  = abcd_r + 4'd1;
            wait_s  = 4'd0;
            state_s = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_WAIT) || (state_s == ST_CHECK);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      abcd_r  <= 4'd0;
      wait_r  <= 4'd0;
      gold_r  <= 16'h0000;
      cnt_r   <= 5'd0;
      first_r <= 4'd0;
      valid_r <= 1'b0;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      abcd_r  <= abcd_s;
      wait_r  <= wait_s;
      gold_r  <= gold_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      valid_r <= valid_s;
      pass_r  <= pass_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign abcd         = abcd_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign mismatch_cnt = cnt_r;
  assign first_fail   = first_r;
  assign fail_valid   = valid_r;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Scoreboard bench for func_sweep_ctrl: a bench-side model predicts each
// sweep's results, which are queued at start and checked when the sweep ends.
module tb_func_sweep_ctrl;

  typedef struct packed {
    logic [4:0] cnt;
    logic [3:0] first;
    logic       valid;
    logic       pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] golden = 16'h0000;
  logic        s_sop, s_pos;
  logic [3:0]  abcd;
  logic        busy, done, pass, fail_valid;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  logic [15:0] golden_ref = 16'h5363;
  logic [15:0] sop_mask   = 16'h0000;
  logic        pos_stuck0 = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  func_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
    .s_sop(s_sop), .s_pos(s_pos), .abcd(abcd), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // Behavioural stand-ins for the two implementations under test.
  always_comb begin
    s_sop = golden_ref[abcd] ^ sop_mask[abcd];
    s_pos = pos_stuck0 ? 1'b0 : golden_ref[abcd];
  end

  function automatic exp_t model_sweep(input logic [15:0] g, input int nvec);
    exp_t e;
    logic sop_v, pos_v;
    e = '0;
    for (int v = 0; v < nvec; v++) begin
      sop_v = g[v] ^ sop_mask[v];
      pos_v = pos_stuck0 ? 1'b0 : g[v];
      if (sop_v != g[v] || pos_v != g[v]) begin
        if (!e.valid) begin
          e.first = 4'(v);
          e.valid = 1'b1;
        end
        e.cnt = e.cnt + 5'd1;
      end
    end
    e.pass = (nvec == 16) && (e.cnt == 5'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({abcd, busy, done, pass, mismatch_cnt, first_fail, fail_valid} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_state: got abcd=%0d busy=%b done=%b pass=%b cnt=%0d first=%0d valid=%b, want all 0",
               abcd, busy, done, pass, mismatch_cnt, first_fail, fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sweep(input string name, input logic hold_start, input int gold_change_at);
    exp_t e, got;
    int   dones, done_at;
    e = model_sweep(golden_ref, 16);
    exp_q.push_back(e);
    golden = golden_ref;
    start  = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    dones = 0;
    done_at = -1;
    for (int n = 0; n <= 33; n++) begin
      if (n > 0) tick();
      if (n == gold_change_at) golden = 16'h0000;
      if (n < 32) begin
        n_cmp++;
        if (abcd !== 4'(n / 2) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s_trace: edge %0d got abcd=%0d busy=%b, want abcd=%0d busy=1",
                   name, n, abcd, busy, n / 2);
        end
      end
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
    end
    n_cmp++;
    if (dones != 1 || done_at != 32) begin
      n_err++;
      $display("FAIL %s_done: got %0d pulses first at edge %0d, want 1 pulse at edge 32", name, dones, done_at);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: got busy=%b after done, want 0", name, busy);
    end
    got = '{cnt: mismatch_cnt, first: first_fail, valid: fail_valid, pass: pass};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue, want one entry", name);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s_result: got cnt=%0d first=%0d valid=%b pass=%b, want cnt=%0d first=%0d valid=%b pass=%b",
                 name, got.cnt, got.first, got.valid, got.pass, e.cnt, e.first, e.valid, e.pass);
      end
    end
    if (hold_start) begin
      // start still high: the next sweep is taken only from IDLE, one edge later
      tick();
      n_cmp++;
      if (busy !== 1'b1 || abcd !== 4'd0) begin
        n_err++;
        $display("FAIL %s_restart: got busy=%b abcd=%0d, want busy=1 abcd=0", name, busy, abcd);
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end else begin
      repeat (4) tick();
      n_cmp++;
      if ({mismatch_cnt, first_fail, fail_valid, pass} !== e || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s_hold: got cnt=%0d first=%0d valid=%b pass=%b done=%b, want results held, done=0",
                 name, mismatch_cnt, first_fail, fail_valid, pass, done);
      end
    end
  endtask

  task automatic test_nominal();
    sop_mask = 16'h0000; pos_stuck0 = 1'b0;
    run_sweep("nominal", 1'b0, -1);
  endtask

  task automatic test_stuck_pos();
    sop_mask = 16'h0000; pos_stuck0 = 1'b1;
    run_sweep("stuck_pos", 1'b0, -1);
    pos_stuck0 = 1'b0;
  endtask

  task automatic test_single_fault();
    sop_mask = 16'h2000; pos_stuck0 = 1'b0;
    run_sweep("single_fault", 1'b0, -1);
    sop_mask = 16'h0000;
  endtask

  task automatic test_hold_start();
    sop_mask = 16'h0000; pos_stuck0 = 1'b0;
    run_sweep("hold_start", 1'b1, 10);
    golden = golden_ref;
  endtask

  task automatic test_abort(input string name, input logic [3:0] target, input logic in_check, input int nvec);
    exp_t e, got;
    int   waited;
    sop_mask = 16'h0014; pos_stuck0 = 1'b0;
    exp_q.push_back(model_sweep(golden_ref, nvec));
    golden = golden_ref;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    waited = 0;
    while (abcd !== target && waited < 60) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (abcd !== target) begin
      n_err++;
      $display("FAIL %s_timeout: got abcd=%0d, want %0d within 60 cycles", name, abcd, target);
    end
    if (in_check) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || abcd !== 4'd0) begin
      n_err++;
      $display("FAIL %s_idle: got busy=%b done=%b abcd=%0d, want 0 0 0", name, busy, done, abcd);
    end
    got = '{cnt: mismatch_cnt, first: first_fail, valid: fail_valid, pass: pass};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s_result: got cnt=%0d first=%0d valid=%b pass=%b, want cnt=%0d first=%0d valid=%b pass=%b",
               name, got.cnt, got.first, got.valid, got.pass, e.cnt, e.first, e.valid, e.pass);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_no_done: got done=%b busy=%b %0d cycles after abort, want 0 0", name, done, busy, k + 1);
        break;
      end
    end
    sop_mask = 16'h0000;
  endtask

  task automatic test_abort_start_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || abcd !== 4'd0) begin
      n_err++;
      $display("FAIL abort_start_idle: got busy=%b abcd=%0d, want busy=0 abcd=0", busy, abcd);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int waited;
    golden = golden_ref;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    waited = 0;
    while (abcd !== 4'd9 && waited < 60) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (abcd !== 4'd9) begin
      n_err++;
      $display("FAIL reset_mid_timeout: got abcd=%0d, want 9 within 60 cycles", abcd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({abcd, busy, done, pass, mismatch_cnt, first_fail, fail_valid} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got abcd=%0d busy=%b done=%b pass=%b cnt=%0d first=%0d valid=%b, want all 0",
               abcd, busy, done, pass, mismatch_cnt, first_fail, fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("after_reset", 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck_pos();
    test_single_fault();
    test_abort("abort_wait", 4'd5, 1'b0, 5);
    test_abort("abort_check", 4'd4, 1'b1, 4);
    test_abort_start_idle();
    test_hold_start();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/func_sweep_ctrl.md
FUNC_SWEEP_CTRL -- requirements
Module: func_sweep_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, the number of wait cycles per vector before sampling (legal range 1..15).
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a 16-vector sweep; accepted only in IDLE.
REQ-006 abort  input  1  synchronous abort of a running sweep.
REQ-007 golden  input  16  expected truth table; bit i is the expected output for vector i = {a,b,c,d}, with a as MSB.
REQ-008 s_sop  input  1  output of the sum-of-products implementation under test.
REQ-009 s_pos  input  1  output of the product-of-sums implementation under test.
REQ-010 abcd  output  4  registered vector driven to both implementations: abcd[3]=a, abcd[0]=d.
REQ-011 busy  output  1  high while a sweep is running (states WAIT and CHECK).
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-014 mismatch_cnt  output  5  number of failing vectors in the current or last sweep (0..16).
REQ-015 first_fail  output  4  index of the first failing vector.
REQ-016 fail_valid  output  1  high when first_fail holds a valid index.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, CHECK, DONE.
REQ-018 IDLE: when start=1 and abort=0, the block SHALL latch golden, clear mismatch_cnt, first_fail, fail_valid and pass, set abcd=0, clear the wait counter, and go to WAIT.
REQ-019 WAIT: abcd SHALL be held stable for SETTLE cycles, then the FSM SHALL go to CHECK.
REQ-020 CHECK: a vector SHALL fail if s_sop != gold[abcd] or s_pos != gold[abcd], using the latched copy; each vector SHALL be counted at most once.
REQ-021 CHECK, on a failing vector: mismatch_cnt SHALL increment; if fail_valid=0, first_fail SHALL be set to abcd and fail_valid set to 1.
REQ-022 CHECK, transition: if abcd=15 the FSM SHALL go to DONE; otherwise abcd SHALL increment and the FSM SHALL go to WAIT.
REQ-023 abcd SHALL never wrap from 15 to 0 within a sweep.
REQ-024 DONE: done=1 for exactly one cycle; pass SHALL be set to (mismatch_cnt==0), including the final vector's update; the FSM SHALL then go to IDLE.
REQ-025 Latency: done SHALL be high in the cycle that begins 16*(SETTLE+1) rising edges after the edge that accepted start (32 for SETTLE=1).
REQ-026 start in WAIT, CHECK or DONE SHALL be ignored, with no restart and no queuing.
REQ-027 abort=1 in WAIT or CHECK SHALL send the FSM to IDLE at the next edge, with no done pulse; pass SHALL be 0; mismatch_cnt, first_fail and fail_valid SHALL retain their partial values; abcd SHALL be 0.
REQ-028 abort=1 in the same cycle as a CHECK SHALL take priority: that vector SHALL not be counted.
REQ-029 abort and start both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-030 A change on golden during a sweep SHALL have no effect; only the copy latched at start SHALL be used.
REQ-031 Results (pass, mismatch_cnt, first_fail, fail_valid) SHALL hold until the next accepted start.
REQ-032 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-033 rst_n=0 SHALL, asynchronously and at any time including mid-sweep, force state=IDLE, abcd=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, fail_valid=0, and clear the latched golden copy and the wait counter.
REQ-034 After rst_n rises, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Verification
REQ-035 Nominal sweep: SETTLE=1, golden=16'h5363, s_sop=s_pos=golden[abcd] -> abcd steps 0..15 holding 2 cycles each; done at edge 32; pass=1, mismatch_cnt=0, fail_valid=0.
REQ-036 Stuck output: golden=16'h5363, s_pos tied to 0, s_sop correct -> mismatch_cnt=8, first_fail=0, fail_valid=1, pass=0.
REQ-037 Single fault: s_sop inverted only at vector 13, s_pos correct -> mismatch_cnt=1, first_fail=13, pass=0; vector 13 counted once.
REQ-038 Abort: abort pulsed while abcd=5 with faults injected at vectors 2 and 4 -> IDLE next cycle, no done, busy=0, mismatch_cnt=2, first_fail=2, pass=0.
REQ-039 Ignored start and golden change: start held high for the whole sweep and golden changed to 16'h0000 mid-sweep -> exactly one done; results match REQ-035; a new sweep starts only after returning to IDLE.
REQ-040 Reset mid-sweep: rst_n dropped while abcd=9, between clock edges -> all outputs 0 immediately; a fresh sweep after release completes per REQ-035.
